// File: rtl/exe_seq_ctrl.sv
// exe_seq_ctrl: multi-cycle sequencer for the execute datapath.
//
// Accepts one decoded instruction at a time over an in_valid/in_ready
// handshake. It steps the instruction through ALU evaluation (EXEC), an
// optional multi-cycle ALU wait (ALU_WAIT) and an optional load/store access
// (MEM), then retires it in a single write-back cycle (WB). This block is the
// only driver of the register-file write enable and of the memory request port.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_*              decoded instruction fields from decode (valid/ready)
//   alu_control       latched ALU operation select
//   alu_start         one-cycle start pulse for a multi-cycle ALU operation
//   alu_done          multi-cycle result valid
//   alu_result        ALU result or effective address
//   mem_req/we/addr/wdata, mem_ack, mem_rdata   load/store memory port
//   rf_wen/rf_rd/rf_wdata                        register-file write port
//   commit            one-cycle pulse when the instruction retires
//   busy              sequencer is not idle
//   err               (EXE_SEQ_CTRL_TIMEOUT_EN only) sticky MEM watchdog error
//
// Optional feature: define EXE_SEQ_CTRL_TIMEOUT_EN to add a MEM-state watchdog.
// After TIMEOUT MEM cycles without mem_ack the request is dropped, the
// instruction retires without a register write and err is raised until reset.
//
// Every output is taken from a register or from registered fields gated by a
// registered control flag, so no input reaches an output combinationally.

module exe_seq_ctrl #(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [11:0]     in_alu_control,
    input  logic [4:0]      in_rd,
    input  logic            in_rf_wen,
    input  logic            in_is_load,
    input  logic            in_is_store,
    input  logic            in_is_multi,
    input  logic [XLEN-1:0] in_store_data,
    output logic [11:0]     alu_control,
    output logic            alu_start,
    input  logic            alu_done,
    input  logic [XLEN-1:0] alu_result,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rf_wen,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic            commit,
`ifdef EXE_SEQ_CTRL_TIMEOUT_EN
    output logic            busy,
    output logic            err
`else
    output logic            busy
`endif
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_EXEC     = 3'd1,
        S_ALU_WAIT = 3'd2,
        S_MEM      = 3'd3,
        S_WB       = 3'd4
    } state_t;

    state_t state;

    // Registered control outputs
    logic ready_q;
    logic start_q;
    logic req_q;
    logic commit_q;
    logic wen_out_q;
    logic have_op_q;

    // Latched instruction fields and result (data path, not reset)
    logic [11:0]     alu_ctrl_q;
    logic [4:0]      rd_q;
    logic            rf_wen_q;
    logic            is_load_q;
    logic            is_store_q;
    logic [XLEN-1:0] store_data_q;
    logic [XLEN-1:0] res_q;

    logic accept;
    logic wb_wen;

    assign accept = (state == S_IDLE) && ready_q && in_valid;
    // Stores never write the register file and x0 is hard-wired to zero.
    assign wb_wen = rf_wen_q && (rd_q != 5'd0) && !is_store_q;

`ifdef EXE_SEQ_CTRL_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] to_cnt;
    logic             err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ready_q   <= 1'b0;
            start_q   <= 1'b0;
            req_q     <= 1'b0;
            commit_q  <= 1'b0;
            wen_out_q <= 1'b0;
            have_op_q <= 1'b0;
`ifdef EXE_SEQ_CTRL_TIMEOUT_EN
            to_cnt    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            start_q   <= 1'b0;
            commit_q  <= 1'b0;
            wen_out_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        ready_q   <= 1'b0;
                        have_op_q <= 1'b1;
                        if (in_is_multi) begin
                            state   <= S_ALU_WAIT;
                            start_q <= 1'b1;
                        end else begin
                            state <= S_EXEC;
                        end
                    end else begin
                        // Also raises in_ready on the first cycle out of reset.
                        ready_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (is_load_q || is_store_q) begin
                        state <= S_MEM;
                        req_q <= 1'b1;
`ifdef EXE_SEQ_CTRL_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                    end else begin
                        state     <= S_WB;
                        commit_q  <= 1'b1;
                        wen_out_q <= wb_wen;
                    end
                end
                S_ALU_WAIT: begin
                    if (alu_done) begin
                        state     <= S_WB;
                        commit_q  <= 1'b1;
                        wen_out_q <= wb_wen;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        req_q     <= 1'b0;
                        state     <= S_WB;
                        commit_q  <= 1'b1;
                        wen_out_q <= wb_wen;
                    end
`ifdef EXE_SEQ_CTRL_TIMEOUT_EN
                    else if (to_cnt == CNT_LAST) begin
                        // Abandon the access: retire with no write, flag error.
                        req_q    <= 1'b0;
                        state    <= S_WB;
                        commit_q <= 1'b1;
                        err_q    <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + CNT_W'(1);
                    end
`endif
                end
                S_WB: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b0;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            alu_ctrl_q   <= in_alu_control;
            rd_q         <= in_rd;
            rf_wen_q     <= in_rf_wen;
            // Multi-cycle ops never touch memory.
            is_load_q    <= in_is_load  && !in_is_multi;
            is_store_q   <= in_is_store && !in_is_multi;
            store_data_q <= in_store_data;
        end
        if (state == S_EXEC) begin
            res_q <= alu_result;
        end else if ((state == S_ALU_WAIT) && alu_done) begin
            res_q <= alu_result;
        end else if ((state == S_MEM) && mem_ack && is_load_q) begin
            res_q <= mem_rdata;
        end
    end

    // Data outputs are gated by registered control flags so they read 0
    // whenever the corresponding port is idle, including during reset.
    assign in_ready    = ready_q;
    assign alu_control = have_op_q ? alu_ctrl_q : 12'd0;
    assign alu_start   = start_q;
    assign mem_req     = req_q;
    assign mem_we      = req_q && is_store_q;
    assign mem_addr    = req_q ? res_q : '0;
    assign mem_wdata   = req_q ? store_data_q : '0;
    assign rf_wen      = wen_out_q;
    assign rf_rd       = commit_q ? rd_q : 5'd0;
    assign rf_wdata    = commit_q ? res_q : '0;
    assign commit      = commit_q;
    assign busy        = (state != S_IDLE);
`ifdef EXE_SEQ_CTRL_TIMEOUT_EN
    assign err         = err_q;
`endif

endmodule

// File: tb/tb_exe_seq_ctrl.sv
// Directed testbench for exe_seq_ctrl. Inputs are driven and outputs sampled
// 1 time unit after the rising edge; all outputs are registered so they are
// stable there. Expected values are hand-derived cycle by cycle.
module tb_exe_seq_ctrl;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [11:0]     in_alu_control;
    logic [4:0]      in_rd;
    logic            in_rf_wen;
    logic            in_is_load;
    logic            in_is_store;
    logic            in_is_multi;
    logic [XLEN-1:0] in_store_data;
    logic [11:0]     alu_control;
    logic            alu_start;
    logic            alu_done;
    logic [XLEN-1:0] alu_result;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;
    logic            rf_wen;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic            commit;
    logic            busy;
`ifdef EXE_SEQ_CTRL_TIMEOUT_EN
    logic            err;
`endif

    int n_run;
    int n_fail;

    exe_seq_ctrl #(.XLEN(XLEN), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_control(in_alu_control), .in_rd(in_rd), .in_rf_wen(in_rf_wen),
        .in_is_load(in_is_load), .in_is_store(in_is_store), .in_is_multi(in_is_multi),
        .in_store_data(in_store_data),
        .alu_control(alu_control), .alu_start(alu_start),
        .alu_done(alu_done), .alu_result(alu_result),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .commit(commit),
`ifdef EXE_SEQ_CTRL_TIMEOUT_EN
        .busy(busy),
        .err(err)
`else
        .busy(busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid       = 1'b0;
        in_alu_control = 12'd0;
        in_rd          = 5'd0;
        in_rf_wen      = 1'b0;
        in_is_load     = 1'b0;
        in_is_store    = 1'b0;
        in_is_multi    = 1'b0;
        in_store_data  = '0;
        alu_done       = 1'b0;
        alu_result     = '0;
        mem_ack        = 1'b0;
        mem_rdata      = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick(); tick(); tick();
        n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0h expected 0", in_ready); end
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h expected 0", busy); end
        n_run++; if ({mem_req, mem_we, commit, rf_wen, alu_start} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, commit, rf_wen, alu_start}); end
        n_run++; if (alu_control !== 12'd0) begin n_fail++; $display("FAIL reset_alu_control: got %h expected 000", alu_control); end
        n_run++; if ({mem_addr, mem_wdata, rf_wdata} !== '0 || rf_rd !== 5'd0) begin n_fail++; $display("FAIL reset_data: got addr=%h wdata=%h rfw=%h rd=%0d expected all 0", mem_addr, mem_wdata, rf_wdata, rf_rd); end
`ifdef EXE_SEQ_CTRL_TIMEOUT_EN
        n_run++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0h expected 0", err); end
`endif
        rst = 1'b0;
        tick();
        n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %0h expected 1", in_ready); end
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %0h expected 0", busy); end
    endtask

    task automatic test_simple();
        in_valid = 1'b1; in_rd = 5'd5; in_rf_wen = 1'b1; in_alu_control = 12'h0A5;
        alu_result = 64'h1234;
        tick();  // EXEC
        in_valid = 1'b0; in_rd = 5'd0; in_alu_control = 12'h000;
        n_run++; if (in_ready !== 1'b0 || busy !== 1'b1 || commit !== 1'b0) begin n_fail++; $display("FAIL simple_exec: got ready=%0h busy=%0h commit=%0h expected 0 1 0", in_ready, busy, commit); end
        n_run++; if (alu_control !== 12'h0A5) begin n_fail++; $display("FAIL simple_alu_control: got %h expected 0a5", alu_control); end
        tick();  // WB
        alu_result = '0;
        n_run++; if (commit !== 1'b1 || rf_wen !== 1'b1) begin n_fail++; $display("FAIL simple_wb: got commit=%0h rf_wen=%0h expected 1 1", commit, rf_wen); end
        n_run++; if (rf_rd !== 5'd5 || rf_wdata !== 64'h1234) begin n_fail++; $display("FAIL simple_wb_data: got rd=%0d wdata=%h expected 5 1234", rf_rd, rf_wdata); end
        tick();  // IDLE
        n_run++; if (in_ready !== 1'b1 || commit !== 1'b0 || rf_wen !== 1'b0) begin n_fail++; $display("FAIL simple_idle: got ready=%0h commit=%0h rf_wen=%0h expected 1 0 0", in_ready, commit, rf_wen); end
        n_run++; if (alu_control !== 12'h0A5) begin n_fail++; $display("FAIL simple_alu_control_hold: got %h expected 0a5", alu_control); end
    endtask

    task automatic test_load();
        int req_cycles;
        req_cycles = 0;
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd7; in_rf_wen = 1'b1;
        alu_result = 64'h8000_0010;
        tick();  // EXEC
        in_valid = 1'b0; in_is_load = 1'b0;
        tick();  // first MEM cycle
        alu_result = 64'h0;
        for (int i = 0; i < 4; i++) begin
            if (mem_req === 1'b1) req_cycles++;
            n_run++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 64'h8000_0010) begin n_fail++; $display("FAIL load_mem_req%0d: got req=%0h we=%0h addr=%h expected 1 0 80000010", i, mem_req, mem_we, mem_addr); end
            if (i == 3) begin mem_ack = 1'b1; mem_rdata = 64'hDEAD_BEEF; end
            tick();
        end
        mem_ack = 1'b0; mem_rdata = '0;
        n_run++; if (req_cycles != 4 || mem_req !== 1'b0) begin n_fail++; $display("FAIL load_req_len: got %0d cycles req_now=%0h expected 4 and 0", req_cycles, mem_req); end
        n_run++; if (commit !== 1'b1 || rf_wen !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL load_wb: got commit=%0h wen=%0h rd=%0d wdata=%h expected 1 1 7 deadbeef", commit, rf_wen, rf_rd, rf_wdata); end
        tick();
    endtask

    task automatic test_store();
        in_valid = 1'b1; in_is_store = 1'b1; in_store_data = 64'hAA; in_rf_wen = 1'b1; in_rd = 5'd3;
        alu_result = 64'h100;
        tick();  // EXEC
        in_valid = 1'b0; in_is_store = 1'b0; in_store_data = '0;
        tick();  // MEM
        n_run++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 64'hAA || mem_addr !== 64'h100) begin n_fail++; $display("FAIL store_mem: got req=%0h we=%0h wdata=%h addr=%h expected 1 1 aa 100", mem_req, mem_we, mem_wdata, mem_addr); end
        mem_ack = 1'b1;
        tick();  // WB
        mem_ack = 1'b0;
        n_run++; if (commit !== 1'b1 || rf_wen !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL store_wb: got commit=%0h rf_wen=%0h req=%0h expected 1 0 0", commit, rf_wen, mem_req); end
        tick();
    endtask

    task automatic test_multi();
        int starts;
        int not_ready;
        starts = 0;
        not_ready = 0;
        // Store flag set alongside multi must be ignored.
        in_valid = 1'b1; in_is_multi = 1'b1; in_is_store = 1'b1; in_rd = 5'd9; in_rf_wen = 1'b1;
        tick();  // ALU_WAIT start cycle
        in_valid = 1'b0; in_is_multi = 1'b0; in_is_store = 1'b0;
        if (alu_start === 1'b1) starts++;
        if (in_ready === 1'b0) not_ready++;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (alu_start === 1'b1) starts++;
            if (in_ready === 1'b0) not_ready++;
            n_run++; if (commit !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL multi_wait%0d: got commit=%0h req=%0h expected 0 0", k, commit, mem_req); end
            if (k == 5) begin alu_done = 1'b1; alu_result = 64'd42; end
        end
        tick();  // WB
        alu_done = 1'b0; alu_result = '0;
        n_run++; if (starts != 1) begin n_fail++; $display("FAIL multi_start_pulses: got %0d expected 1", starts); end
        n_run++; if (not_ready != 6) begin n_fail++; $display("FAIL multi_in_ready: got %0d low cycles expected 6", not_ready); end
        n_run++; if (commit !== 1'b1 || rf_wen !== 1'b1 || rf_wdata !== 64'd42 || rf_rd !== 5'd9) begin n_fail++; $display("FAIL multi_wb: got commit=%0h wen=%0h wdata=%0d rd=%0d expected 1 1 42 9", commit, rf_wen, rf_wdata, rf_rd); end
        tick();
    endtask

    task automatic test_x0_and_spurious();
        mem_ack = 1'b1; alu_done = 1'b1;
        tick(); tick();
        mem_ack = 1'b0; alu_done = 1'b0;
        n_run++; if (busy !== 1'b0 || in_ready !== 1'b1 || commit !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL spurious_idle: got busy=%0h ready=%0h commit=%0h req=%0h expected 0 1 0 0", busy, in_ready, commit, mem_req); end
        in_valid = 1'b1; in_rd = 5'd0; in_rf_wen = 1'b1; alu_result = 64'h5;
        tick();
        in_valid = 1'b0;
        tick();  // WB
        n_run++; if (commit !== 1'b1 || rf_wen !== 1'b0) begin n_fail++; $display("FAIL x0_wb: got commit=%0h rf_wen=%0h expected 1 0", commit, rf_wen); end
        tick();
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_rd = 5'd1; in_rf_wen = 1'b1; alu_result = 64'h11;
        tick();  // EXEC 1
        in_rd = 5'd2;
        tick();  // WB 1
        n_run++; if (rf_rd !== 5'd1 || rf_wdata !== 64'h11 || commit !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got rd=%0d wdata=%h commit=%0h expected 1 11 1", rf_rd, rf_wdata, commit); end
        alu_result = 64'h22;
        tick();  // IDLE, second accept this cycle
        n_run++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got ready=%0h busy=%0h expected 1 0", in_ready, busy); end
        tick();  // EXEC 2
        in_valid = 1'b0;
        tick();  // WB 2
        n_run++; if (rf_rd !== 5'd2 || rf_wdata !== 64'h22 || commit !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got rd=%0d wdata=%h commit=%0h expected 2 22 1", rf_rd, rf_wdata, commit); end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid_mem();
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd4; in_rf_wen = 1'b1; alu_result = 64'h200;
        tick();  // EXEC
        in_valid = 1'b0; in_is_load = 1'b0;
        tick();  // MEM wait 1
        tick();  // MEM wait 2
        n_run++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmem_pre: got req=%0h expected 1", mem_req); end
        rst = 1'b1;
        tick();
        n_run++; if (mem_req !== 1'b0 || commit !== 1'b0 || rf_wen !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmem_abort: got req=%0h commit=%0h wen=%0h ready=%0h expected 0 0 0 0", mem_req, commit, rf_wen, in_ready); end
        rst = 1'b0;
        tick();
        n_run++; if (busy !== 1'b0 || in_ready !== 1'b1 || commit !== 1'b0) begin n_fail++; $display("FAIL rstmem_after: got busy=%0h ready=%0h commit=%0h expected 0 1 0", busy, in_ready, commit); end
        clear_inputs();
    endtask

`ifdef EXE_SEQ_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int req_cycles;
        req_cycles = 0;
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd6; in_rf_wen = 1'b1; alu_result = 64'h300;
        tick();  // EXEC
        in_valid = 1'b0; in_is_load = 1'b0;
        tick();  // MEM 1
        for (int i = 0; i < 4; i++) begin
            if (mem_req === 1'b1) req_cycles++;
            tick();
        end
        n_run++; if (req_cycles != 4) begin n_fail++; $display("FAIL timeout_req_len: got %0d expected 4", req_cycles); end
        n_run++; if (err !== 1'b1 || commit !== 1'b1 || rf_wen !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL timeout_wb: got err=%0h commit=%0h wen=%0h req=%0h expected 1 1 0 0", err, commit, rf_wen, mem_req); end
        tick(); tick();
        n_run++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %0h expected 1", err); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_run++; if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %0h expected 0", err); end
        tick();
        clear_inputs();
    endtask
`endif

    initial begin
        n_run  = 0;
        n_fail = 0;
        test_reset();
        test_simple();
        test_load();
        test_store();
        test_multi();
        test_x0_and_spurious();
        test_back_to_back();
        test_reset_mid_mem();
`ifdef EXE_SEQ_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_seq_ctrl.md
Name: exe_seq_ctrl

Overview:
- Multi-cycle sequencer for the execute datapath: the register file, the ALU and the load/store memory port.
- Accepts one decoded instruction at a time from decode over a valid/ready handshake.
- Steps the instruction through ALU evaluation, an optional multi-cycle ALU wait, an optional memory access and register write-back.
- Sole owner of the register-file write enable and the memory request port.

Parameters:
- XLEN, 64, datapath width.
- TIMEOUT, 255, maximum MEM-state wait cycles before watchdog error; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  controller can accept an instruction.
- in_alu_control  in  12  ALU operation select.
- in_rd  in  5  destination register.
- in_rf_wen  in  1  instruction writes rd.
- in_is_load  in  1  load instruction.
- in_is_store  in  1  store instruction.
- in_is_multi  in  1  multi-cycle ALU operation (mul/div).
- in_store_data  in  XLEN  store data.
- alu_control  out  12  latched ALU operation to the ALU.
- alu_start  out  1  one-cycle start pulse for a multi-cycle operation.
- alu_done  in  1  multi-cycle result valid.
- alu_result  in  XLEN  ALU output; result or effective address.
- mem_req  out  1  memory request.
- mem_we  out  1  write (store) request.
- mem_addr  out  XLEN  memory address.
- mem_wdata  out  XLEN  store data.
- mem_ack  in  1  memory completes the request.
- mem_rdata  in  XLEN  load data, valid with mem_ack.
- rf_wen  out  1  register-file write enable.
- rf_rd  out  5  write address.
- rf_wdata  out  XLEN  write data.
- commit  out  1  one-cycle pulse at instruction retire.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset and output timing:
  - Reset is synchronous. While rst is high, every output is 0, including in_ready.
  - In the first cycle after rst falls: state is IDLE and in_ready=1.
  - All outputs decode from registered state and registered fields; there is no combinational path from any input to any output.
- State IDLE:
  - in_ready=1.
  - When in_valid=1, latch all in_* fields.
  - Next state is ALU_WAIT if in_is_multi=1, otherwise EXEC.
  - When in_is_multi=1, the load/store flags are ignored and treated as 0.
- State EXEC (exactly 1 cycle):
  - Latch alu_result into res_q.
  - Next state is MEM if load or store, otherwise WB.
- State ALU_WAIT:
  - alu_start=1 only in the first cycle of ALU_WAIT.
  - alu_done is honoured in any ALU_WAIT cycle, including the start cycle.
  - On alu_done=1, latch alu_result into res_q and go to WB.
  - No time limit.
- State MEM:
  - mem_req=1, mem_addr=res_q, mem_we=is_store_q, mem_wdata=store_data_q.
  - All four are held stable until mem_ack=1.
  - On mem_ack=1 for a load, latch mem_rdata into res_q.
  - After mem_ack, next state is WB; mem_req is 0 in that WB cycle.
- State WB (exactly 1 cycle):
  - rf_wen = rf_wen_q AND (rd_q != 0) AND NOT is_store_q.
  - rf_rd=rd_q, rf_wdata=res_q, commit=1.
  - Next state is IDLE.
- alu_control drives the latched value from the cycle after accept until the next accept.
- Latency, accept edge to commit cycle:
  - Simple op: 2 cycles (EXEC, WB).
  - Memory op: 3 + wait cycles.
  - Multi-cycle op: 2 + ALU latency.
  - Throughput is at most one instruction per 3 cycles (IDLE, EXEC, WB).
- Writes to x0 never assert rf_wen but still pulse commit.
- Inputs that are not qualified by state are ignored, e.g. mem_ack outside MEM or alu_done outside ALU_WAIT.
- Reset mid-operation aborts the instruction. The cycle after reset shows mem_req=0, commit=0, rf_wen=0. There is no partial write.

Optional Feature:
- Macro: EXE_SEQ_CTRL_TIMEOUT_EN.
- When defined:
  - A counter runs in MEM and clears on MEM entry.
  - If TIMEOUT cycles pass without mem_ack, the controller drops mem_req, goes to WB with rf_wen forced to 0, and asserts the extra output port err (1 bit) with commit.
  - err is sticky until rst.
- When undefined: the err port and the counter are absent, and MEM waits indefinitely.

Test Plan:
- Simple op: in_valid=1, in_rd=5, in_rf_wen=1, alu_result=0x1234 -> rf_wen=1, rf_rd=5, rf_wdata=0x1234, commit 2 cycles after accept; in_ready=1 again in the following cycle.
- Load: alu_result=0x80000010, mem_ack after 3 wait cycles, mem_rdata=0xDEADBEEF -> mem_req high 4 cycles with mem_addr=0x80000010 and mem_we=0; rf_wdata=0xDEADBEEF; commit 6 cycles after accept.
- Store: in_is_store=1, in_store_data=0xAA, in_rf_wen=1, immediate mem_ack -> mem_we=1, mem_wdata=0xAA, rf_wen=0, commit=1.
- Multi-cycle: in_is_multi=1, alu_done 5 cycles after alu_start, alu_result=42 -> alu_start high exactly 1 cycle, rf_wdata=42, commit the cycle after done; in_ready=0 throughout.
- rd=0 with in_rf_wen=1 -> rf_wen=0, commit=1. Spurious mem_ack/alu_done in IDLE -> no state change.
- rst asserted in the 2nd MEM wait cycle -> next cycle mem_req=0, no commit, busy=0 one cycle after rst falls. With EXE_SEQ_CTRL_TIMEOUT_EN and TIMEOUT=4, no ack -> err=1, commit=1, rf_wen=0.
